// File: rtl/pwm_kanal.sv
// Single-channel PWM generator with fixed-duty and breathing modes.
// Configuration is shadowed and applied at period boundaries.
module pwm_kanal #(
  parameter int VERI_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          ctrl_i,
  input  logic [VERI_BIT-1:0] period_i,
  input  logic [VERI_BIT-1:0] threshold_1_i,
  input  logic [VERI_BIT-1:0] threshold_2_i,
  input  logic [VERI_BIT-1:0] step_i,
  output logic                pwm_o,
  output logic                periyot_bitti_o,
  output logic [VERI_BIT-1:0] sayac_o
);

  typedef enum logic {
    KAPALI    = 1'b0,
    CALISIYOR = 1'b1
  } durum_t;

  localparam logic [VERI_BIT-1:0] ONE = {{(VERI_BIT-1){1'b0}}, 1'b1};
  localparam logic [VERI_BIT-1:0] ZERO = '0;
  localparam logic [1:0] M_NEFES = 2'b10;

  durum_t              r_durum;
  durum_t              w_durum_n;
  logic [1:0]          r_mode;
  logic [VERI_BIT-1:0] r_period;
  logic [VERI_BIT-1:0] r_th1;
  logic [VERI_BIT-1:0] r_th2;
  logic [VERI_BIT-1:0] r_step;
  logic [VERI_BIT-1:0] r_sayac;
  logic [VERI_BIT-1:0] r_duty;
  logic                r_yon_up;
  logic                r_pwm;
  logic                r_pulse;

  logic                w_en;
  logic                w_son;
  logic                w_sinir;
  logic [VERI_BIT-1:0] w_cmp;
  logic                w_pwm_n;
  logic [VERI_BIT:0]   w_sum;
  logic [VERI_BIT:0]   w_lim;
  logic [VERI_BIT-1:0] w_duty_n;
  logic                w_yon_n;
  logic                w_nefese_gecis;

  assign w_en    = (ctrl_i == 2'b01) || (ctrl_i == 2'b10);
  assign w_son   = (r_period != ZERO) && (r_sayac == r_period - ONE);
  assign w_sinir = (r_period == ZERO) || w_son;
  assign w_cmp   = (r_mode == M_NEFES) ? r_duty : r_th1;
  assign w_pwm_n = (r_period != ZERO) && (r_sayac < w_cmp);
  assign w_sum   = {1'b0, r_duty} + {1'b0, r_step};
  assign w_lim   = {1'b0, r_th1} + {1'b0, r_step};
  assign w_nefese_gecis = (ctrl_i == M_NEFES) && (r_mode != M_NEFES);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_durum <= KAPALI;
    else       r_durum <= w_durum_n;
  end

  // Next state: enable starts counting, disable stops immediately
  always_comb begin
    w_durum_n = r_durum;
    unique case (r_durum)
      KAPALI:    if (w_en)  w_durum_n = CALISIYOR;
      CALISIYOR: if (!w_en) w_durum_n = KAPALI;
      default:   w_durum_n = KAPALI;
    endcase
  end

  // Breathing duty update, evaluated in one extra bit so it never wraps
  always_comb begin
    w_duty_n = r_duty;
    w_yon_n  = r_yon_up;
    if (r_th1 >= r_th2) begin
      w_duty_n = r_th1;
    end else if (r_step == ZERO) begin
      w_duty_n = r_duty;
    end else if (r_yon_up) begin
      if (w_sum >= {1'b0, r_th2}) begin
        w_duty_n = r_th2;
        w_yon_n  = 1'b0;
      end else begin
        w_duty_n = w_sum[VERI_BIT-1:0];
      end
    end else begin
      if ({1'b0, r_duty} <= w_lim) begin
        w_duty_n = r_th1;
        w_yon_n  = 1'b1;
      end else begin
        w_duty_n = r_duty - r_step;
      end
    end
  end

  // Counter, shadows, duty and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode   <= 2'b00;
      r_period <= '0;
      r_th1    <= '0;
      r_th2    <= '0;
      r_step   <= '0;
      r_sayac  <= '0;
      r_duty   <= '0;
      r_yon_up <= 1'b1;
      r_pwm    <= 1'b0;
      r_pulse  <= 1'b0;
    end else if (r_durum == KAPALI) begin
      r_sayac <= '0;
      r_pwm   <= 1'b0;
      r_pulse <= 1'b0;
      if (w_en) begin
        r_mode   <= ctrl_i;
        r_period <= period_i;
        r_th1    <= threshold_1_i;
        r_th2    <= threshold_2_i;
        r_step   <= step_i;
        r_duty   <= threshold_1_i;
        r_yon_up <= 1'b1;
      end
    end else if (!w_en) begin
      r_sayac <= '0;
      r_pwm   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pwm   <= w_pwm_n;
      r_pulse <= w_son;
      if (w_sinir) begin
        r_sayac  <= '0;
        r_mode   <= ctrl_i;
        r_period <= period_i;
        r_th1    <= threshold_1_i;
        r_th2    <= threshold_2_i;
        r_step   <= step_i;
        if (w_nefese_gecis) begin
          r_duty   <= threshold_1_i;
          r_yon_up <= 1'b1;
        end else if (r_mode == M_NEFES) begin
          r_duty   <= w_duty_n;
          r_yon_up <= w_yon_n;
        end
      end else begin
        r_sayac <= r_sayac + ONE;
      end
    end
  end

  assign pwm_o           = r_pwm;
  assign periyot_bitti_o = r_pulse;
  assign sayac_o         = r_sayac;

endmodule

// File: tb/tb_pwm_kanal.sv
// Scoreboard bench for pwm_kanal against a period-level model.
// Model pushes per-cycle expectations; monitor pops and compares.
module tb_pwm_kanal;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [1:0]   ctrl;
  logic [W-1:0] per;
  logic [W-1:0] th1;
  logic [W-1:0] th2;
  logic [W-1:0] stp;
  logic         pwm;
  logic         pulse;
  logic [W-1:0] sayac;

  typedef struct {
    logic         pwm;
    logic         pulse;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pwm_kanal #(.VERI_BIT(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ctrl_i         (ctrl),
    .period_i       (per),
    .threshold_1_i  (th1),
    .threshold_2_i  (th2),
    .step_i         (stp),
    .pwm_o          (pwm),
    .periyot_bitti_o(pulse),
    .sayac_o        (sayac)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // model state
  bit     m_on;
  logic [1:0] m_mode;
  longint m_per, m_t1, m_t2, m_st, m_cnt, m_duty;
  bit     m_up;

  function automatic bit enabled(logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  task automatic load_cfg();
    m_mode = ctrl;
    m_per  = longint'(per);
    m_t1   = longint'(th1);
    m_t2   = longint'(th2);
    m_st   = longint'(stp);
  endtask

  // Duty sweep for the next period: clamp at the bounds and reverse
  task automatic breathe();
    longint d;
    if (m_t1 >= m_t2) begin
      m_duty = m_t1;
    end else if (m_st != 0) begin
      if (m_up) begin
        d = m_duty + m_st;
        if (d >= m_t2) begin d = m_t2; m_up = 0; end
      end else begin
        d = m_duty - m_st;
        if (d <= m_t1) begin d = m_t1; m_up = 1; end
      end
      m_duty = d;
    end
  endtask

  task automatic model_edge(output exp_t e);
    longint lvl;
    e.pwm = 0; e.pulse = 0; e.cnt = '0;
    if (rst) begin
      m_on = 0; m_mode = 0; m_per = 0; m_t1 = 0;
      m_t2 = 0; m_st = 0; m_cnt = 0; m_duty = 0; m_up = 1;
    end else if (!m_on) begin
      m_cnt = 0;
      if (enabled(ctrl)) begin
        load_cfg();
        m_duty = longint'(th1);
        m_up = 1;
        m_on = 1;
      end
    end else if (!enabled(ctrl)) begin
      m_on = 0;
      m_cnt = 0;
    end else begin
      lvl = (m_mode == 2'b10) ? m_duty : m_t1;
      e.pwm   = (m_per != 0) && (m_cnt < lvl);
      e.pulse = (m_per != 0) && (m_cnt == m_per - 1);
      if (m_per == 0 || m_cnt == m_per - 1) begin
        m_cnt = 0;
        if (ctrl == 2'b10 && m_mode != 2'b10) begin
          m_duty = longint'(th1);
          m_up = 1;
        end else if (m_mode == 2'b10) begin
          breathe();
        end
        load_cfg();
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.cnt = W'(m_cnt);
  endtask

  // model: one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      model_edge(e);
      sb.push_back(e);
    end
  end

  // monitor: pop and compare after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (pwm !== e.pwm) begin
          errors++;
          $display("FAIL pwm t=%0t got %0b want %0b", $time, pwm, e.pwm);
        end
        checks++;
        if (pulse !== e.pulse) begin
          errors++;
          $display("FAIL pulse t=%0t got %0b want %0b", $time, pulse, e.pulse);
        end
        checks++;
        if (sayac !== e.cnt) begin
          errors++;
          $display("FAIL sayac t=%0t got %0d want %0d", $time, sayac, e.cnt);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(string nm);
    checks++;
    if (pwm !== 1'b0 || pulse !== 1'b0 || sayac !== '0) begin
      errors++;
      $display("FAIL %s got pwm=%0b pulse=%0b sayac=%0d want all 0",
               nm, pwm, pulse, sayac);
    end
  endtask

  task automatic wait_cnt(logic [W-1:0] v);
    int k;
    k = 0;
    while (sayac !== v && k < 40) begin
      cyc(1);
      k++;
    end
    checks++;
    if (sayac !== v) begin
      errors++;
      $display("FAIL wait_cnt got %0d want %0d", sayac, v);
    end
  endtask

  task automatic cfg(logic [1:0] c, int p, int a, int b, logic [W-1:0] s);
    ctrl = c; per = W'(p); th1 = W'(a); th2 = W'(b); stp = s;
  endtask

  initial begin
    rst = 1;
    cfg(2'b00, 0, 0, 0, '0);
    cyc(3);
    chk_zero("reset_state");
    rst = 0;

    cfg(2'b01, 10, 4, 0, '0);
    cyc(27);
    #2 rst = 1;
    #1 chk_zero("async_reset");
    cyc(2);
    rst = 0;
    cyc(35);

    cfg(2'b01, 8, 2, 0, '0);
    cyc(12);
    wait_cnt(W'(3));
    th1 = W'(6);
    cyc(24);

    cfg(2'b01, 0, 2, 0, '0);
    cyc(10);
    cfg(2'b01, 5, 9, 0, '0);
    cyc(12);
    th1 = '0;
    cyc(12);

    cfg(2'b10, 10, 2, 8, W'(3));
    cyc(70);
    stp = W'(4);
    cyc(70);

    cfg(2'b01, 10, 3, 0, '0);
    cyc(12);
    wait_cnt(W'(5));
    ctrl = 2'b00;
    cyc(1);
    chk_zero("disable");
    cfg(2'b01, 7, 5, 0, '0);
    cyc(20);

    cfg(2'b10, 10, 7, 3, W'(1));
    cyc(40);
    ctrl = 2'b11;
    cyc(2);
    cfg(2'b10, 10, 2, 8, 32'hFFFF_FFFF);
    cyc(40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ctrl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) per = W'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) th1 = W'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0) th2 = W'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0)
        stp = ($urandom_range(0, 7) == 0) ? $urandom() : W'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1;
        #1 chk_zero("rand_reset");
        cyc(1);
        rst = 0;
      end
      cyc(1);
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
